tick_period_meter: RTL and testbench
====================================

// Module: tick_period_meter
// PURPOSE
//  Receive-side companion to the divide-by-N tick generator: measures the spacing of a
//  single-cycle tick stream and reports N, where ticks N+1 clocks apart give period N.
//  Recovers and checks baud/strobe rates produced by a divider elsewhere in the design.
//  Flags lock once the period is stable, and flags overflow when ticks stop.
// PARAMETERS
//  N_BIT       16   width of the cycle counter and the period output
//  LOCK_COUNT  4    consecutive identical measurements required to assert locked (>=2)
// PORTS
//  clock         in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high reset
//  enable        in   1      1 = operate; 0 = freeze all state, ignore tick_in
//  tick_in       in   1      single-cycle tick pulse to be measured
//  period        out  N_BIT  last measured period (cycles between ticks minus 1)
//  period_valid  out  1      one-cycle pulse: period updated this cycle
//  locked        out  1      LOCK_COUNT consecutive equal periods seen
//  overflow      out  1      counter saturated without a tick; sticky until next tick
// BEHAVIOUR
//  Reset (reset=1 at edge, overrides enable): state=IDLE, cnt=0, match=0,
//   period=0, period_valid=0, locked=0, overflow=0. Mid-measurement reset discards all.
//  enable=0: every register holds; period_valid forced 0; ticks that cycle are lost.
//  States:
//   IDLE     - no reference tick yet. tick_in -> MEASURE, cnt<=0, no valid pulse.
//   MEASURE  - cnt<=cnt+1 each enabled cycle without tick.
//              tick_in -> period<=cnt, period_valid<=1, cnt<=0, stay MEASURE.
//              no tick and cnt==all-ones -> OVERFLOW, overflow<=1, locked<=0, match<=0.
//   OVERFLOW - cnt holds at all-ones; period holds last value.
//              tick_in -> MEASURE, cnt<=0, overflow<=0, no valid pulse (new reference).
//  Timing: ticks at enabled cycles t and t+N+1 -> period=N and period_valid=1 in the
//   cycle after the edge sampling the second tick (1-cycle latency, registered outputs).
//  Back-to-back ticks (every cycle) -> period=0 each cycle, period_valid held high.
//  Tick with cnt==all-ones is a valid measurement of 2^N_BIT-1; overflow is not set.
//  Lock tracking (on each measurement, width ceil(log2(LOCK_COUNT+1)), saturating):
//   first measurement after IDLE/OVERFLOW/reset -> match<=1.
//   new cnt == current period -> match<=min(match+1, LOCK_COUNT).
//   new cnt != current period -> match<=1, locked<=0.
//   locked<=1 when updated match==LOCK_COUNT; asserts same cycle as that valid pulse.
//   locked drops same cycle as the mismatching period_valid, or on overflow entry.
//  Comparison is against period register before update; all arithmetic unsigned N_BIT.
// TESTING
//  1 reset=1 for 2 cycles with ticks toggling -> all outputs 0, state IDLE.
//  2 ticks every 6 cycles (N=5), 6 ticks -> 5 valid pulses, period=5; locked rises with
//    4th valid pulse (LOCK_COUNT=4), 1 cycle after the 5th tick.
//  3 locked at N=5, switch to N=3 spacing -> next valid: period=3, locked=0; relock
//    after 4 equal periods of 3.
//  4 tick_in high every cycle -> period=0, period_valid continuously 1 after 2nd tick,
//    locked from 4th valid.
//  5 N_BIT=4, one tick then silence -> overflow=1 after cnt reaches 15, locked=0;
//    next tick clears overflow, no valid; following tick 3 cycles later -> period=2.
//  6 enable=0 for 10 cycles mid-period N=5 -> no output change, cnt frozen; resume ->
//    period=5+0 (frozen cycles not counted); reset mid-period -> outputs 0, IDLE.

Source files
------------

// File: rtl/tick_period_meter.sv
`default_nettype none
// ============================================================================
// tick_period_meter : measures single-cycle tick spacing, reports lock/overflow
// Rev 1.0
// ============================================================================
module tick_period_meter #(
  parameter int N_BIT      = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  output logic [N_BIT-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEASURE  = 2'd1;
  localparam logic [1:0] S_OVERFLOW = 2'd2;

  localparam logic [N_BIT-1:0] CNT_MAX   = '1;
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  logic [1:0]       state, state_nxt;
  logic [N_BIT-1:0] cnt, cnt_nxt;
  logic [MW-1:0]    match, match_nxt, match_inc;
  logic [N_BIT-1:0] period_nxt;
  logic             valid_nxt, locked_nxt, overflow_nxt;

  // State and all registered outputs; enable=0 freezes everything but the pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
    end else if (enable) begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      match        <= match_nxt;
      period       <= period_nxt;
      period_valid <= valid_nxt;
      locked       <= locked_nxt;
      overflow     <= overflow_nxt;
    end else begin
      period_valid <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (tick_in) state_nxt = S_MEASURE;
      S_MEASURE:  if (!tick_in && cnt == CNT_MAX) state_nxt = S_OVERFLOW;
      S_OVERFLOW: if (tick_in) state_nxt = S_MEASURE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign match_inc = (match == MATCH_MAX) ? match : match + MATCH_ONE;

  always_comb begin
    cnt_nxt      = cnt;
    match_nxt    = match;
    period_nxt   = period;
    valid_nxt    = 1'b0;
    locked_nxt   = locked;
    overflow_nxt = overflow;
    case (state)
      S_IDLE: begin
        if (tick_in) cnt_nxt = '0;
      end
      S_MEASURE: begin
        if (tick_in) begin
          period_nxt = cnt;
          valid_nxt  = 1'b1;
          cnt_nxt    = '0;
          // match==0 marks the first measurement after a fresh reference
          if (match != '0 && cnt == period) match_nxt = match_inc;
          else                               match_nxt = MATCH_ONE;
          locked_nxt = (match_nxt == MATCH_MAX);
        end else if (cnt == CNT_MAX) begin
          overflow_nxt = 1'b1;
          locked_nxt   = 1'b0;
          match_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_OVERFLOW: begin
        if (tick_in) begin
          cnt_nxt      = '0;
          overflow_nxt = 1'b0;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`default_nettype none
// ============================================================================
// tb_tick_period_meter : directed self-checking bench (16-bit and 4-bit DUTs)
// Rev 1.0
// ============================================================================
module tb_tick_period_meter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        tick_in = 1'b0;

  logic [15:0] period16;
  logic        valid16, locked16, ovf16;
  logic [3:0]  period4;
  logic        valid4, locked4, ovf4;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tick_period_meter #(.N_BIT(16), .LOCK_COUNT(4)) dut16 (
    .clock(clock), .reset(reset), .enable(enable), .tick_in(tick_in),
    .period(period16), .period_valid(valid16), .locked(locked16), .overflow(ovf16)
  );

  tick_period_meter #(.N_BIT(4), .LOCK_COUNT(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .tick_in(tick_in),
    .period(period4), .period_valid(valid4), .locked(locked4), .overflow(ovf4)
  );

  task automatic cyc(input logic t);
    tick_in = t;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero16(input string tag);
    chk({tag, "_period"}, 32'(period16), 0);
    chk({tag, "_valid"}, 32'(valid16), 0);
    chk({tag, "_locked"}, 32'(locked16), 0);
    chk({tag, "_ovf"}, 32'(ovf16), 0);
  endtask

  initial begin
    // 1: reset with toggling ticks
    reset = 1'b1;
    cyc(1);
    cyc(0);
    chk_zero16("rst");
    chk("rst_ovf4", 32'(ovf4), 0);
    reset = 1'b0;

    // 2: N=5 spacing, lock on the 4th valid pulse
    cyc(1);
    chk("ref_novalid", 32'(valid16), 0);
    for (int k = 1; k <= 5; k++) begin
      for (int z = 0; z < 5; z++) cyc(0);
      chk("n5_gap_novalid", 32'(valid16), 0);
      cyc(1);
      chk("n5_valid", 32'(valid16), 1);
      chk("n5_period", 32'(period16), 5);
      chk("n5_locked", 32'(locked16), (k >= 4) ? 32'd1 : 32'd0);
    end

    // 3: switch to N=3, lock drops then returns after 4 equal periods
    for (int j = 1; j <= 4; j++) begin
      for (int z = 0; z < 3; z++) cyc(0);
      cyc(1);
      chk("n3_valid", 32'(valid16), 1);
      chk("n3_period", 32'(period16), 3);
      chk("n3_locked", 32'(locked16), (j == 4) ? 32'd1 : 32'd0);
    end

    // 4: back-to-back ticks after a fresh reset
    reset = 1'b1;
    cyc(0);
    chk_zero16("rst2");
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("b2b_valid", 32'(valid16), (i >= 2) ? 32'd1 : 32'd0);
      chk("b2b_period", 32'(period16), 0);
      chk("b2b_locked", 32'(locked16), (i >= 5) ? 32'd1 : 32'd0);
    end

    // 5: silence on the 4-bit meter until it overflows
    cyc(1);
    chk("pre_ovf_locked4", 32'(locked4), 1);
    for (int z = 0; z < 15; z++) cyc(0);
    chk("cnt15_ovf4", 32'(ovf4), 0);
    chk("cnt15_locked4", 32'(locked4), 1);
    cyc(0);
    chk("ovf4_set", 32'(ovf4), 1);
    chk("ovf4_unlocked", 32'(locked4), 0);
    for (int z = 0; z < 4; z++) cyc(0);
    chk("ovf4_sticky", 32'(ovf4), 1);
    chk("ovf4_period_hold", 32'(period4), 0);
    chk("ovf16_clear", 32'(ovf16), 0);
    cyc(1);
    chk("ovf4_cleared", 32'(ovf4), 0);
    chk("ovf4_exit_novalid", 32'(valid4), 0);
    chk("p16_after20", 32'(period16), 20);
    chk("v16_after20", 32'(valid16), 1);
    chk("l16_after20", 32'(locked16), 0);
    cyc(0);
    cyc(0);
    cyc(1);
    chk("p4_2", 32'(period4), 2);
    chk("v4_2", 32'(valid4), 1);
    chk("l4_2", 32'(locked4), 0);
    for (int z = 0; z < 15; z++) cyc(0);
    cyc(1);
    chk("p4_max", 32'(period4), 15);
    chk("v4_max", 32'(valid4), 1);
    chk("o4_max", 32'(ovf4), 0);
    chk("p16_15", 32'(period16), 15);

    // 6: freeze with enable=0 right after a tick; ticks during freeze are lost
    for (int z = 0; z < 5; z++) cyc(0);
    cyc(1);
    chk("pre_freeze_p", 32'(period16), 5);
    chk("pre_freeze_v", 32'(valid16), 1);
    enable = 1'b0;
    for (int z = 0; z < 10; z++) begin
      cyc(z[0] ? 1'b0 : 1'b1);
      chk("frz_valid", 32'(valid16), 0);
    end
    chk("frz_period", 32'(period16), 5);
    chk("frz_ovf4", 32'(ovf4), 0);
    enable = 1'b1;
    for (int z = 0; z < 5; z++) cyc(0);
    cyc(1);
    chk("resume_period", 32'(period16), 5);
    chk("resume_valid", 32'(valid16), 1);

    // reset mid-period discards the measurement in progress
    cyc(0);
    cyc(0);
    reset = 1'b1;
    cyc(0);
    chk_zero16("rst3");
    reset = 1'b0;
    for (int z = 0; z < 3; z++) cyc(0);
    cyc(1);
    chk("rst3_ref_novalid", 32'(valid16), 0);
    chk("rst3_ref_period", 32'(period16), 0);
    for (int z = 0; z < 5; z++) cyc(0);
    cyc(1);
    chk("rst3_period", 32'(period16), 5);
    chk("rst3_valid", 32'(valid16), 1);
    chk("rst3_locked", 32'(locked16), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
